// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
//
// Purpose:
//   8-line interrupt controller. It edge-detects the device request lines into
//   a pending set, which the register file reads raw as r0[15:8]. It selects the
//   highest-priority line that is enabled by the r1[15:8] mask (line 0 is the
//   highest) and offers it to the core sequencer with a req/ack handshake. It
//   then tracks one in-service handler until end-of-interrupt. There is no
//   nesting.
//
// Ports:
//   clk        in   1   clock, rising edge
//   _reset     in   1   asynchronous, active-high reset
//   dev_irq    in   8   device request lines (a rising edge requests service)
//   int_mask   in   8   per-line enable mask
//   clr_en     in   1   software clear strobe
//   clr_mask   in   8   pending bits cleared when clr_en=1
//   irq_ack    in   1   core accepts the offered interrupt
//   eoi        in   1   core finished the in-service handler
//   int_flags  out  8   registered pending set (unmasked)
//   irq_req    out  1   interrupt offered to the core
//   irq_id     out  3   offered / in-service line index
//   irq_vector out  16  VecBase + irq_id*VecStride, modulo 2^16
//   in_service out  1   a handler is active
// -----------------------------------------------------------------------------
module int_controller #(
  parameter int          NumLines  = 8,
  parameter logic [15:0] VecBase   = 16'h0100,
  parameter logic [15:0] VecStride = 16'd4
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic [NumLines-1:0] dev_irq,
  input  logic [NumLines-1:0] int_mask,
  input  logic                clr_en,
  input  logic [NumLines-1:0] clr_mask,
  input  logic                irq_ack,
  input  logic                eoi,
  output logic [NumLines-1:0] int_flags,
  output logic                irq_req,
  output logic [2:0]          irq_id,
  output logic [15:0]         irq_vector,
  output logic                in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state_q;
  logic [NumLines-1:0] dev_irq_q;
  logic [NumLines-1:0] pending_q;
  logic [NumLines-1:0] pending_d;
  logic [2:0]          irq_id_q;
  logic [15:0]         irq_vector_q;
  logic                irq_req_q;
  logic                in_service_q;

  logic [NumLines-1:0] rise;
  logic [NumLines-1:0] eligible;
  logic [NumLines-1:0] sw_clr;
  logic [NumLines-1:0] ack_clr;
  logic                accept;
  logic [2:0]          sel_id;
  logic [15:0]         sel_vector;

  assign rise     = dev_irq & ~dev_irq_q;
  assign eligible = pending_q & int_mask;
  assign accept   = (state_q == REQ) && irq_ack;
  assign sw_clr   = clr_en ? clr_mask : '0;
  assign ack_clr  = accept ? ({{(NumLines-1){1'b0}}, 1'b1} << irq_id_q) : '0;

  // A new edge re-sets a bit even when a clear hits the same bit in the
  // same cycle, so a request that arrives during the clear is never lost.
  assign pending_d = rise | (pending_q & ~(sw_clr | ack_clr));

  // Lowest set eligible bit wins. Scanning downwards lets the lowest index
  // overwrite the higher ones.
  always_comb begin
    sel_id = '0;
    for (int i = NumLines - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_id = 3'(i);
      end
    end
  end

  assign sel_vector = VecBase + (16'(sel_id) * VecStride);

  always_ff @(posedge clk or posedge _reset) begin
    if (_reset) begin
      state_q      <= IDLE;
      dev_irq_q    <= '0;
      pending_q    <= '0;
      irq_id_q     <= '0;
      irq_vector_q <= VecBase;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      dev_irq_q <= dev_irq;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (eligible != '0) begin
            state_q      <= REQ;
            irq_id_q     <= sel_id;
            irq_vector_q <= sel_vector;
            irq_req_q    <= 1'b1;
          end
        end
        REQ: begin
          // The offer stays frozen. A higher-priority arrival waits until the
          // next IDLE pass. When ack and withdraw happen together, ack wins.
          if (irq_ack) begin
            state_q      <= SERVICE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!eligible[irq_id_q]) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_flags  = pending_q;
  assign irq_req    = irq_req_q;
  assign irq_id     = irq_id_q;
  assign irq_vector = irq_vector_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_controller.sv
// -----------------------------------------------------------------------------
// tb_int_controller
//
// Purpose:
//   Self-checking bench for int_controller. Each step drives the inputs and
//   pushes the expected output set onto a scoreboard queue. It then advances
//   one clock (or a short delay when checking async reset), pops the expected
//   set and compares every output field.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_int_controller;

  logic        clk = 1'b0;
  logic        _reset;
  logic [7:0]  dev_irq;
  logic [7:0]  int_mask;
  logic        clr_en;
  logic [7:0]  clr_mask;
  logic        irq_ack;
  logic        eoi;
  logic [7:0]  int_flags;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [15:0] irq_vector;
  logic        in_service;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [7:0]  f;
    logic        r;
    logic [2:0]  id;
    logic [15:0] v;
    logic        s;
  } exp_t;

  exp_t sb_q[$];

  int_controller dut (
    .clk        (clk),
    ._reset     (_reset),
    .dev_irq    (dev_irq),
    .int_mask   (int_mask),
    .clr_en     (clr_en),
    .clr_mask   (clr_mask),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .int_flags  (int_flags),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_vector (irq_vector),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] f, input logic r,
                          input logic [2:0] id, input logic [15:0] v, input logic s);
    exp_t e;
    e.tag = tag; e.f = f; e.r = r; e.id = id; e.v = v; e.s = s;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb_q.pop_front();
    $display("txn %-12s flags=%02h req=%0b id=%0d vec=%04h srv=%0b",
             e.tag, int_flags, irq_req, irq_id, irq_vector, in_service);
    chk({e.tag, ".flags"}, 32'(int_flags),  32'(e.f));
    chk({e.tag, ".req"},   32'(irq_req),    32'(e.r));
    chk({e.tag, ".id"},    32'(irq_id),     32'(e.id));
    chk({e.tag, ".vec"},   32'(irq_vector), 32'(e.v));
    chk({e.tag, ".srv"},   32'(in_service), 32'(e.s));
  endtask

  // The expectation applies to the outputs just after the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] f, input logic r,
                     input logic [2:0] id, input logic [15:0] v, input logic s);
    push_exp(tag, f, r, id, v, s);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // The expectation applies immediately, with no clock edge in between.
  task automatic now_chk(input string tag, input logic [7:0] f, input logic r,
                         input logic [2:0] id, input logic [15:0] v, input logic s);
    push_exp(tag, f, r, id, v, s);
    #1;
    compare_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    _reset = 1'b1; dev_irq = '0; int_mask = 8'hFF; clr_en = 1'b0;
    clr_mask = '0; irq_ack = 1'b0; eoi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    now_chk("reset", 8'h00, 0, 3'd0, 16'h0100, 0);
    _reset = 1'b0;

    // 1. Single request on line 3
    dev_irq = 8'h08;
    cyc("t1.pend",   8'h08, 0, 3'd0, 16'h0100, 0);
    cyc("t1.offer",  8'h08, 1, 3'd3, 16'h010C, 0);
    irq_ack = 1;
    cyc("t1.ack",    8'h00, 0, 3'd3, 16'h010C, 1);
    irq_ack = 0; dev_irq = 8'h00;
    cyc("t1.hold",   8'h00, 0, 3'd3, 16'h010C, 1);
    eoi = 1;
    cyc("t1.eoi",    8'h00, 0, 3'd3, 16'h010C, 0);
    eoi = 0;

    // 2. Priority: lines 5 and 2 together
    dev_irq = 8'h24;
    cyc("t2.pend",   8'h24, 0, 3'd3, 16'h010C, 0);
    cyc("t2.offer2", 8'h24, 1, 3'd2, 16'h0108, 0);
    irq_ack = 1;
    cyc("t2.ack2",   8'h20, 0, 3'd2, 16'h0108, 1);
    irq_ack = 0; dev_irq = 8'h00; eoi = 1;
    cyc("t2.eoi2",   8'h20, 0, 3'd2, 16'h0108, 0);
    eoi = 0;
    cyc("t2.offer5", 8'h20, 1, 3'd5, 16'h0114, 0);
    irq_ack = 1;
    cyc("t2.ack5",   8'h00, 0, 3'd5, 16'h0114, 1);
    irq_ack = 0; eoi = 1;
    cyc("t2.eoi5",   8'h00, 0, 3'd5, 16'h0114, 0);
    eoi = 0;

    // 3. Masking and withdraw
    int_mask = 8'h00; dev_irq = 8'h01;
    cyc("t3.pend",   8'h01, 0, 3'd5, 16'h0114, 0);
    cyc("t3.masked", 8'h01, 0, 3'd5, 16'h0114, 0);
    cyc("t3.masked2",8'h01, 0, 3'd5, 16'h0114, 0);
    int_mask = 8'h01;
    cyc("t3.offer0", 8'h01, 1, 3'd0, 16'h0100, 0);
    int_mask = 8'h00;
    cyc("t3.wdraw",  8'h01, 0, 3'd0, 16'h0100, 0);
    dev_irq = 8'h00; clr_en = 1; clr_mask = 8'h01;
    cyc("t3.clr",    8'h00, 0, 3'd0, 16'h0100, 0);
    clr_en = 0; int_mask = 8'hFF;

    // 4. Set/clear collision, then ack together with clear
    clr_en = 1; clr_mask = 8'h10; dev_irq = 8'h10;
    cyc("t4.setwin", 8'h10, 0, 3'd0, 16'h0100, 0);
    clr_en = 0;
    cyc("t4.offer4", 8'h10, 1, 3'd4, 16'h0110, 0);
    irq_ack = 1; clr_en = 1;
    cyc("t4.ackclr", 8'h00, 0, 3'd4, 16'h0110, 1);
    irq_ack = 0; clr_en = 0; dev_irq = 8'h00; eoi = 1;
    cyc("t4.eoi",    8'h00, 0, 3'd4, 16'h0110, 0);
    eoi = 0;

    // 5. No nesting while line 6 is in service
    dev_irq = 8'h40;
    cyc("t5.pend6",  8'h40, 0, 3'd4, 16'h0110, 0);
    cyc("t5.offer6", 8'h40, 1, 3'd6, 16'h0118, 0);
    irq_ack = 1;
    cyc("t5.ack6",   8'h00, 0, 3'd6, 16'h0118, 1);
    irq_ack = 0; dev_irq = 8'h01;
    cyc("t5.nonest", 8'h01, 0, 3'd6, 16'h0118, 1);
    dev_irq = 8'h00;
    cyc("t5.nonest2",8'h01, 0, 3'd6, 16'h0118, 1);
    irq_ack = 1;  // ack outside REQ must be ignored
    cyc("t5.stray",  8'h01, 0, 3'd6, 16'h0118, 1);
    irq_ack = 0; eoi = 1;
    cyc("t5.eoi6",   8'h01, 0, 3'd6, 16'h0118, 0);
    eoi = 0;
    cyc("t5.offer0", 8'h01, 1, 3'd0, 16'h0100, 0);
    irq_ack = 1;
    cyc("t5.ack0",   8'h00, 0, 3'd0, 16'h0100, 1);
    irq_ack = 0; eoi = 1;
    cyc("t5.eoi0",   8'h00, 0, 3'd0, 16'h0100, 0);
    eoi = 0;

    // Level hold: line 1 is held high for 20 clocks and must set pending once
    int_mask = 8'h00; dev_irq = 8'h02;
    cyc("t5.lvlset", 8'h02, 0, 3'd0, 16'h0100, 0);
    clr_en = 1; clr_mask = 8'h02;
    cyc("t5.lvlclr", 8'h00, 0, 3'd0, 16'h0100, 0);
    clr_en = 0;
    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("t5.lvl%0d", i), 8'h00, 0, 3'd0, 16'h0100, 0);
    end
    dev_irq = 8'h00; int_mask = 8'hFF;

    // 6. Async reset in REQ and in SERVICE
    dev_irq = 8'h08;
    cyc("t6.pend",   8'h08, 0, 3'd0, 16'h0100, 0);
    cyc("t6.offer",  8'h08, 1, 3'd3, 16'h010C, 0);
    #1 _reset = 1'b1;
    now_chk("t6.rstreq", 8'h00, 0, 3'd0, 16'h0100, 0);
    #1 _reset = 1'b0;
    cyc("t6.relpend",8'h08, 0, 3'd0, 16'h0100, 0);
    cyc("t6.reoffer",8'h08, 1, 3'd3, 16'h010C, 0);
    irq_ack = 1;
    cyc("t6.ack",    8'h00, 0, 3'd3, 16'h010C, 1);
    irq_ack = 0;
    #1 _reset = 1'b1;
    now_chk("t6.rstsrv", 8'h00, 0, 3'd0, 16'h0100, 0);
    #1 _reset = 1'b0;
    cyc("t6.relpnd2",8'h08, 0, 3'd0, 16'h0100, 0);

    if (sb_q.size() != 0) begin
      chk("sb.empty", 32'(sb_q.size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
